param_queue: RTL
================

Name: param_queue

Overview:
- Parametrised circular-buffer FIFO; next generation of the board-level occupancy queue.
- Carries a data word per entry and exposes full/empty flags, occupancy count and a thermometer occupancy mask for LED display.
- Sits behind debounced, one-pulsed push/pop strobes in board tops.
- Also usable as a generic single-clock FIFO inside datapaths.

Parameters:
- DATA_W, 8, width of each stored word.
- DEPTH, 16, number of entries; power of two, >= 2.
- CNT_W, $clog2(DEPTH+1), width of the size output; derived, not overridden.

Ports:
- clk  in  1  single system clock; all logic on posedge.
- rst  in  1  synchronous active-high reset.
- push  in  1  single-cycle enqueue strobe.
- push_data  in  DATA_W  word written on accepted push.
- pop  in  1  single-cycle dequeue strobe.
- pop_data  out  DATA_W  head word, first-word-fall-through; 0 when empty.
- full  out  1  size == DEPTH.
- empty  out  1  size == 0.
- size  out  CNT_W  current occupancy, 0..DEPTH.
- valid  out  DEPTH  thermometer mask: bit i = 1 iff i < size.
- overflow  out  1  sticky; present only with QUEUE_ERR_EN.
- underflow  out  1  sticky; present only with QUEUE_ERR_EN.

Behaviour:
- Reset: rst sampled on posedge clk.
  - Sets head=0, tail=0, size=0, empty=1, full=0, valid=0, pop_data=0.
  - Storage array is not reset.
  - Reset wins over any push/pop in the same cycle, including mid-operation; all queued contents are discarded.
- Storage: DEPTH x DATA_W register array.
  - head and tail pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
  - size is held in a separate counter; full/empty are derived from size, never from pointer compare.
- Accept rules, evaluated on the same edge:
  - push_ok = push & (~full | pop).
  - pop_ok = pop & ~empty.
- push_ok: mem[tail] <= push_data; tail <= tail+1.
- pop_ok: head <= head+1.
- size update: size + push_ok - pop_ok.
  - Both accepted: size unchanged.
  - Full with push and pop together: the pop frees the slot and the push is accepted; size stays DEPTH.
  - Empty with push and pop together: pop rejected, push accepted; size becomes 1.
- Rejected operations leave state unchanged:
  - Push while full without pop.
  - Pop while empty.
- pop_data = empty ? 0 : mem[head], combinational from registers.
  - The word is valid in the same cycle it is popped; the next head word appears the following cycle.
- valid, full, empty: combinational decode of the registered size; they update one cycle after the strobe edge.
- Latency: a pushed word is visible on pop_data the cycle after the push if the queue was empty.
- Strobes held high for multiple cycles act once per cycle; the block does no edge detection.

Optional Feature:
- Macro: QUEUE_ERR_EN.
- Defined: overflow and underflow ports exist.
  - overflow sets on any cycle with push & full & ~pop.
  - underflow sets on any cycle with pop & empty.
  - Both are sticky until rst; set-and-hold begins the cycle after the offending edge.
- Undefined: ports and logic are absent; rejected operations are silently dropped.

Decomposition:
- Shared package queue_pkg holds:
  - Default DATA_W/DEPTH constants.
  - The CNT_W derivation function.
  - A thermometer-decode function (size -> DEPTH-bit mask), reused by LED display tops.
- One natural sub-module: queue_thermo, the combinational size-to-mask decoder, so board tops can drive LEDs from any counter.
- Storage and pointers stay in param_queue.

Test Plan:
- Reset then idle, DATA_W=8, DEPTH=16 -> size=0, empty=1, full=0, valid=16'h0000, pop_data=0.
- Push 8'hA1, 8'hB2, 8'hC3 on consecutive cycles -> size=3, valid=16'h0007, pop_data=8'hA1.
  - Then 3 pops -> pop_data A1, B2, C3 in order; finally empty=1.
- Push 16 words 0..15 -> full=1, valid=16'hFFFF.
  - 17th push of 8'hEE without pop -> rejected, size stays 16; overflow=1 if QUEUE_ERR_EN.
  - Pop sequence then returns 0..15 in order.
- Full queue, push 8'h55 with pop in the same cycle -> size stays 16.
  - Popped word 0; 8'h55 emerges last after 15 more pops, confirming tail wrap.
- Empty queue, push 8'h77 with pop in the same cycle -> size=1, pop_data=8'h77; underflow=1 if QUEUE_ERR_EN.
- 10 words queued, rst asserted together with push and pop -> next cycle size=0, empty=1, valid=0, pointers at 0, error flags cleared.

Source files
------------

// File: rtl/queue_pkg.sv
// rtl/queue_pkg.sv - shared constants and helpers for the occupancy queue family
package queue_pkg;

  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_DEPTH  = 16;

  // Widest mask the thermometer helper produces; callers truncate to their depth.
  localparam int THERMO_MAX_W = 256;

  // Occupancy counter width: must hold every value 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Thermometer decode: bit i is set iff i < count.
  function automatic logic [THERMO_MAX_W-1:0] thermo_decode(input int unsigned count);
    logic [THERMO_MAX_W-1:0] mask;
    mask = '0;
    for (int unsigned i = 0; i < THERMO_MAX_W; i++) begin
      mask[i] = (i < count);
    end
    return mask;
  endfunction

endpackage

// File: rtl/queue_thermo.sv
// rtl/queue_thermo.sv - combinational occupancy count to thermometer mask decoder
module queue_thermo
  import queue_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int CNT_W = cnt_width(DEPTH)
) (
  input  logic [CNT_W-1:0] count,
  output logic [DEPTH-1:0] mask
);

  // Decode the count into a mask; bits above DEPTH-1 are dropped by the width cast.
  always_comb begin
    mask = DEPTH'(thermo_decode(32'(count)));
  end

endmodule

// File: rtl/param_queue.sv
// rtl/param_queue.sv - parametrised circular-buffer FIFO with occupancy outputs (optional QUEUE_ERR_EN sticky error flags)
module param_queue
  import queue_pkg::*;
#(
  parameter  int DATA_W = DEFAULT_DATA_W,
  parameter  int DEPTH  = DEFAULT_DEPTH,
  localparam int CNT_W  = cnt_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  size,
  output logic [DEPTH-1:0]  valid
`ifdef QUEUE_ERR_EN
  ,
  output logic              overflow,
  output logic              underflow
`endif
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic              push_ok;
  logic              pop_ok;

  // Flags come from the occupancy counter only, so pointer equality is never ambiguous.
  always_comb begin
    full    = (size == CNT_W'(DEPTH));
    empty   = (size == '0);
    // A pop in the same cycle frees the slot, so a push into a full queue still lands.
    push_ok = push & (~full | pop);
    pop_ok  = pop & ~empty;
    // Head word falls through; forced to zero when nothing is queued.
    pop_data = empty ? '0 : mem[head];
  end

  // Pointer and occupancy state; reset discards all queued contents and beats any strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      size <= '0;
    end else begin
      if (push_ok) begin
        tail <= tail + PTR_W'(1);
      end
      if (pop_ok) begin
        head <= head + PTR_W'(1);
      end
      size <= size + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  // Storage array has no reset; a write is suppressed while reset is asserted.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      mem[tail] <= push_data;
    end
  end

  queue_thermo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_thermo (
    .count (size),
    .mask  (valid)
  );

`ifdef QUEUE_ERR_EN
  // Sticky error flags: record dropped pushes and pops until the next reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push && full && !pop) begin
        overflow <= 1'b1;
      end
      if (pop && empty) begin
        underflow <= 1'b1;
      end
    end
  end
`endif

endmodule
